// File: rtl/poly_ram_2r2w_pkg.sv
// Shared constants and types for the Kyber coefficient store and the NTT units.
package poly_ram_2r2w_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

  typedef logic [DATA_W-1:0] coef_t;

  // The depth can be 65536, so compare with one extra bit to avoid overflow.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr, input int depth);
    return {1'b0, addr} < (ADDR_W+1)'(depth);
  endfunction
endpackage

// File: rtl/poly_ram_rd_port.sv
// One synchronous read port: range check, output register, hold when disabled.
module poly_ram_rd_port
  import poly_ram_2r2w_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  coef_t             word,
  output coef_t             dout
);

  logic hit;
  assign hit = addr_ok(addr, DEPTH);

  // Out-of-range reads return 0 rather than an aliased word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   dout <= '0;
    else if (en) dout <= hit ? word : '0;
  end

endmodule

// File: rtl/poly_ram_2r2w.sv
// Flop-array coefficient store: two read ports, two write ports, read-first.
module poly_ram_2r2w
  import poly_ram_2r2w_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r1_en,
  input  logic              r2_en,
  input  logic              w1_en,
  input  logic              w2_en,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [ADDR_W-1:0] r2_addr,
  input  logic [ADDR_W-1:0] w1_addr,
  input  logic [ADDR_W-1:0] w2_addr,
  input  logic [DATA_W-1:0] d1_in,
  input  logic [DATA_W-1:0] d2_in,
  output logic [DATA_W-1:0] d1_out,
  output logic [DATA_W-1:0] d2_out
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [IDX_W-1:0] w1_idx, w2_idx, r1_idx, r2_idx;
  logic             w1_ok, w2_ok;

  assign w1_idx = w1_addr[IDX_W-1:0];
  assign w2_idx = w2_addr[IDX_W-1:0];
  assign r1_idx = r1_addr[IDX_W-1:0];
  assign r2_idx = r2_addr[IDX_W-1:0];
  assign w1_ok  = w1_en && addr_ok(w1_addr, DEPTH);
  assign w2_ok  = w2_en && addr_ok(w2_addr, DEPTH);

  // Port 2 is applied last, so it wins a same-address collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem <= '0;
    end else begin
      if (w1_ok) mem[w1_idx] <= d1_in;
      if (w2_ok) mem[w2_idx] <= d2_in;
    end
  end

  poly_ram_rd_port #(.DEPTH(DEPTH)) u_rd1 (
    .clk   (clk),
    .reset (reset),
    .en    (r1_en),
    .addr  (r1_addr),
    .word  (mem[r1_idx]),
    .dout  (d1_out)
  );

  poly_ram_rd_port #(.DEPTH(DEPTH)) u_rd2 (
    .clk   (clk),
    .reset (reset),
    .en    (r2_en),
    .addr  (r2_addr),
    .word  (mem[r2_idx]),
    .dout  (d2_out)
  );

endmodule

// File: tb/tb_poly_ram_2r2w.sv
// Directed checks for poly_ram_2r2w at DEPTH=64.
module tb_poly_ram_2r2w;
  logic        clk = 1'b0;
  logic        reset;
  logic        r1_en, r2_en, w1_en, w2_en;
  logic [15:0] r1_addr, r2_addr, w1_addr, w2_addr;
  logic [15:0] d1_in, d2_in;
  logic [15:0] d1_out, d2_out;
  int          n_chk = 0;
  int          n_err = 0;

  poly_ram_2r2w #(64) dut (
    .clk     (clk),
    .reset   (reset),
    .r1_en   (r1_en),
    .r2_en   (r2_en),
    .w1_en   (w1_en),
    .w2_en   (w2_en),
    .r1_addr (r1_addr),
    .r2_addr (r2_addr),
    .w1_addr (w1_addr),
    .w2_addr (w2_addr),
    .d1_in   (d1_in),
    .d2_in   (d2_in),
    .d1_out  (d1_out),
    .d2_out  (d2_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    r1_en = 0; r2_en = 0; w1_en = 0; w2_en = 0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    r1_addr = 0; r2_addr = 0; w1_addr = 0; w2_addr = 0;
    d1_in = 0; d2_in = 0;

    // reads under reset, then after release
    r1_en = 1; r1_addr = 0; r2_en = 1; r2_addr = 63;
    tick();
    chk("rst_d1", d1_out, 16'h0);
    chk("rst_d2", d2_out, 16'h0);
    reset = 1'b0;
    tick();
    chk("post_rst_d1", d1_out, 16'h0);
    chk("post_rst_d2", d2_out, 16'h0);

    // fill 0..9 then read back crosswise
    idle();
    for (int i = 0; i < 10; i++) begin
      w1_en = 1; w1_addr = 16'(i); d1_in = 16'(i);
      tick();
    end
    idle();
    for (int i = 0; i < 10; i++) begin
      r1_en = 1; r1_addr = 16'(i); r2_en = 1; r2_addr = 16'(9 - i);
      tick();
      chk($sformatf("rd1_%0d", i), d1_out, 16'(i));
      chk($sformatf("rd2_%0d", i), d2_out, 16'(9 - i));
    end

    // same-address write collision
    idle();
    w1_en = 1; w1_addr = 5; d1_in = 16'h1111;
    w2_en = 1; w2_addr = 5; d2_in = 16'h2222;
    tick();
    idle();
    r1_en = 1; r1_addr = 5;
    tick();
    chk("collide", d1_out, 16'h2222);

    // out-of-range write must not alias onto word 0
    idle();
    w1_en = 1; w1_addr = 64; d1_in = 16'hBEEF;
    tick();
    idle();
    r1_en = 1; r1_addr = 0; r2_en = 1; r2_addr = 64;
    tick();
    chk("oor_wr_addr0", d1_out, 16'h0);
    chk("oor_rd", d2_out, 16'h0);

    // read-first on same-edge read/write
    idle();
    w1_en = 1; w1_addr = 7; d1_in = 16'h00AA;
    tick();
    w1_addr = 7; d1_in = 16'h00BB; r1_en = 1; r1_addr = 7;
    tick();
    chk("rdw_old", d1_out, 16'h00AA);
    w1_en = 0;
    tick();
    chk("rdw_new", d1_out, 16'h00BB);

    // hold when read disabled
    idle();
    w1_en = 1; w1_addr = 3; d1_in = 16'h1234;
    tick();
    idle();
    r1_en = 1; r1_addr = 3; r2_en = 1; r2_addr = 9;
    tick();
    chk("hold_pre", d1_out, 16'h1234);
    chk("hold_pre_d2", d2_out, 16'h0009);
    idle();
    w1_en = 1; w1_addr = 3; d1_in = 16'h5555;
    tick();
    chk("hold_d1", d1_out, 16'h1234);
    idle();
    tick();
    chk("hold_d1_b", d1_out, 16'h1234);
    chk("hold_d2", d2_out, 16'h0009);

    // async reset pulse between edges
    #2 reset = 1'b1;
    #1;
    chk("async_d1", d1_out, 16'h0);
    chk("async_d2", d2_out, 16'h0);
    reset = 1'b0;
    r1_en = 1; r1_addr = 3; r2_en = 1; r2_addr = 5;
    tick();
    chk("clr_3", d1_out, 16'h0);
    chk("clr_5", d2_out, 16'h0);
    r1_addr = 7; r2_addr = 9;
    tick();
    chk("clr_7", d1_out, 16'h0);
    chk("clr_9", d2_out, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
